// File: rtl/shift_arb_ctrl.sv
// shift_arb_ctrl: shares one N-bit barrel shifter between two requesters.
// Requester 0 is the execute stage and requester 1 is the address/immediate path.
// Grants are round-robin. Results go into a one-deep buffer tagged with the
// owning requester, and each result is held until that owner accepts it.
// Optional feature: define SHIFT_ARB_CTRL_ROTATE_EN to make op 11 a rotate-left.
// Without it, op 11 executes as SLL and no rotate logic is built.
module shift_arb_ctrl #(
  parameter int N = 16,
  parameter int C = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_0,
  input  logic [1:0]   op_0,
  input  logic [N-1:0] in_0,
  input  logic [C-1:0] cnt_0,
  output logic         gnt_0,
  input  logic         req_1,
  input  logic [1:0]   op_1,
  input  logic [N-1:0] in_1,
  input  logic [C-1:0] cnt_1,
  output logic         gnt_1,
  output logic         rsp_valid_0,
  output logic         rsp_valid_1,
  input  logic         rsp_ready_0,
  input  logic         rsp_ready_1,
  output logic [N-1:0] rsp_data,
  output logic         busy
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]   state_reg, state_next;
  logic         tag_reg, tag_next;
  logic         prio_reg, prio_next;   // requester favoured on a tie
  logic [N-1:0] data_reg, data_next;

  logic         owner_ready;
  logic         slot_free;
  logic         grant_any;
  logic         grant_idx;
  logic [1:0]   sel_op;
  logic [N-1:0] sel_in;
  logic [C-1:0] sel_cnt;
  logic [C:0][N-1:0] stage;

  assign owner_ready = tag_reg ? rsp_ready_1 : rsp_ready_0;
  // A full buffer is also free in any cycle where its owner drains it.
  // This lets the buffer drain and reload without a bubble.
  assign slot_free   = (state_reg == EMPTY) || owner_ready;

  // Grant selection: a lone requester wins, and a tie goes to the round-robin favourite
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (slot_free && !rst) begin
      if (req_0 && req_1) begin
        grant_any = 1'b1;
        grant_idx = prio_reg;
      end else if (req_0 || req_1) begin
        grant_any = 1'b1;
        grant_idx = req_1;
      end
    end
  end

  assign gnt_0 = grant_any && !grant_idx;
  assign gnt_1 = grant_any &&  grant_idx;

  assign sel_op  = grant_idx ? op_1  : op_0;
  assign sel_in  = grant_idx ? in_1  : in_0;
  assign sel_cnt = grant_idx ? cnt_1 : cnt_0;

  // Log-depth barrel shifter: stage gi shifts by 2**gi when count bit gi is set
  assign stage[0] = sel_in;
  for (genvar gi = 0; gi < C; gi++) begin : g_stage
    localparam int SH = 2 ** gi;
    logic [N-1:0] shifted;
`ifdef SHIFT_ARB_CTRL_ROTATE_EN
    logic [2*N-1:0] rot_dbl;
    assign rot_dbl = {stage[gi], stage[gi]} << (SH % N);
`endif
    // Per-stage operation select, where op 11 falls back to SLL when rotate is off
    always_comb begin
      case (sel_op)
        2'b01:   shifted = stage[gi] >> SH;
        2'b10:   shifted = $unsigned($signed(stage[gi]) >>> SH);
`ifdef SHIFT_ARB_CTRL_ROTATE_EN
        2'b11:   shifted = rot_dbl[2*N-1:N];
`endif
        default: shifted = stage[gi] << SH;
      endcase
    end
    assign stage[gi+1] = sel_cnt[gi] ? shifted : stage[gi];
  end

  // Next-state logic: a new grant loads the buffer, otherwise an owner accept drains it
  always_comb begin
    state_next = state_reg;
    tag_next   = tag_reg;
    prio_next  = prio_reg;
    data_next  = data_reg;
    if (grant_any) begin
      state_next = FULL;
      tag_next   = grant_idx;
      prio_next  = ~grant_idx;
      data_next  = stage[C];
    end else if (state_reg == FULL && owner_ready) begin
      state_next = EMPTY;
    end
  end

  // State registers, where reset discards any in-flight result at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      tag_reg   <= 1'b0;
      prio_reg  <= 1'b0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      tag_reg   <= tag_next;
      prio_reg  <= prio_next;
      data_reg  <= data_next;
    end
  end

  assign busy        = (state_reg == FULL);
  assign rsp_valid_0 = busy && !tag_reg;
  assign rsp_valid_1 = busy &&  tag_reg;
  assign rsp_data    = data_reg;

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Directed testbench for shift_arb_ctrl, with hand-computed expected values.
// The rotate expectation follows SHIFT_ARB_CTRL_ROTATE_EN, so the bench matches either build.
module tb_shift_arb_ctrl;
  localparam int N = 16;
  localparam int C = 4;

`ifdef SHIFT_ARB_CTRL_ROTATE_EN
  localparam logic [15:0] ROT_EXP = 16'h0003;
`else
  localparam logic [15:0] ROT_EXP = 16'h0002;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req_0, req_1, gnt_0, gnt_1;
  logic [1:0]   op_0, op_1;
  logic [N-1:0] in_0, in_1, rsp_data;
  logic [C-1:0] cnt_0, cnt_1;
  logic         rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1, busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  shift_arb_ctrl #(.N(N), .C(C)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .op_0(op_0), .in_0(in_0), .cnt_0(cnt_0), .gnt_0(gnt_0),
    .req_1(req_1), .op_1(op_1), .in_1(in_1), .cnt_1(cnt_1), .gnt_1(gnt_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_data(rsp_data), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_0 = 1'b1; op_0 = 2'b00; in_0 = '0; cnt_0 = '0;
    req_1 = 1'b0; op_1 = 2'b00; in_1 = '0; cnt_1 = '0;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    #12;
    check("rst_valid0", rsp_valid_0, 0);
    check("rst_valid1", rsp_valid_1, 0);
    check("rst_data", rsp_data, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt0", gnt_0, 0);
    req_0 = 1'b0;
    rst = 1'b0;
    step();

    // Single SLL: 0x0001 << 4
    req_0 = 1; op_0 = 2'b00; in_0 = 16'h0001; cnt_0 = 4'd4;
    #1 check("sll_gnt0", gnt_0, 1);
    check("sll_gnt1", gnt_1, 0);
    step();
    req_0 = 0;
    check("sll_valid0", rsp_valid_0, 1);
    check("sll_valid1", rsp_valid_1, 0);
    check("sll_data", rsp_data, 16'h0010);
    check("sll_busy", busy, 1);
    rsp_ready_0 = 1;
    step();
    check("sll_drain_busy", busy, 0);
    check("sll_drain_valid0", rsp_valid_0, 0);
    rsp_ready_0 = 0;

    // SRA then SRL from requester 1, where the second loads while the first drains
    req_1 = 1; op_1 = 2'b10; in_1 = 16'h8000; cnt_1 = 4'd3;
    #1 check("sra_gnt1", gnt_1, 1);
    step();
    check("sra_valid1", rsp_valid_1, 1);
    check("sra_data", rsp_data, 16'hF000);
    op_1 = 2'b01; rsp_ready_1 = 1;
    #1 check("srl_gnt1", gnt_1, 1);
    step();
    check("srl_valid1", rsp_valid_1, 1);
    check("srl_data", rsp_data, 16'h1000);
    req_1 = 0;
    step();
    check("srl_drain_busy", busy, 0);
    rsp_ready_1 = 0;

    // Contention: a reset restores the favour to requester 0, then grants alternate with no bubble
    rst = 1; #1 rst = 0;
    req_0 = 1; op_0 = 2'b00; in_0 = 16'h0001; cnt_0 = 4'd1;
    req_1 = 1; op_1 = 2'b01; in_1 = 16'h0100; cnt_1 = 4'd4;
    rsp_ready_0 = 1; rsp_ready_1 = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("cont%0d_gnt0", k), gnt_0, (k % 2 == 0));
      check($sformatf("cont%0d_gnt1", k), gnt_1, (k % 2 == 1));
      step();
      check($sformatf("cont%0d_valid0", k), rsp_valid_0, (k % 2 == 0));
      check($sformatf("cont%0d_valid1", k), rsp_valid_1, (k % 2 == 1));
      check($sformatf("cont%0d_data", k), rsp_data, (k % 2 == 0) ? 16'h0002 : 16'h0010);
    end
    req_0 = 0; req_1 = 0;
    step();
    check("cont_drain_busy", busy, 0);
    rsp_ready_0 = 0; rsp_ready_1 = 0;

    // Backpressure: owner 0 holds its result, and ready from the non-owner is ignored
    req_0 = 1; op_0 = 2'b00; in_0 = 16'h00F0; cnt_0 = 4'd4;
    #1 check("bp_gnt0", gnt_0, 1);
    step();
    req_0 = 0;
    req_1 = 1; op_1 = 2'b00; in_1 = 16'h0003; cnt_1 = 4'd2;
    rsp_ready_1 = 1;
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("bp%0d_gnt1", k), gnt_1, 0);
      step();
      check($sformatf("bp%0d_data", k), rsp_data, 16'h0F00);
      check($sformatf("bp%0d_valid0", k), rsp_valid_0, 1);
    end
    rsp_ready_0 = 1; rsp_ready_1 = 0;
    #1 check("bp_release_gnt1", gnt_1, 1);
    step();
    check("bp_release_valid1", rsp_valid_1, 1);
    check("bp_release_valid0", rsp_valid_0, 0);
    check("bp_release_data", rsp_data, 16'h000C);

    // Owner 1 drains in the same cycle that requester 0 is granted (SLL 0xFFFF by 15)
    req_1 = 0; rsp_ready_0 = 0; rsp_ready_1 = 1;
    req_0 = 1; op_0 = 2'b00; in_0 = 16'hFFFF; cnt_0 = 4'd15;
    #1 check("swap_gnt0", gnt_0, 1);
    step();
    check("swap_valid0", rsp_valid_0, 1);
    check("swap_valid1", rsp_valid_1, 0);
    check("swap_data", rsp_data, 16'h8000);
    req_0 = 0; rsp_ready_1 = 0; rsp_ready_0 = 1;
    step();
    check("swap_drain_busy", busy, 0);
    rsp_ready_0 = 0;

    // Reset mid-operation clears the buffer at once, then service resumes
    req_0 = 1; op_0 = 2'b00; in_0 = 16'h0005; cnt_0 = 4'd1;
    #1 check("rmid_gnt0", gnt_0, 1);
    step();
    req_0 = 0;
    check("rmid_loaded", rsp_valid_0, 1);
    rst = 1;
    #1;
    check("rmid_valid0", rsp_valid_0, 0);
    check("rmid_data", rsp_data, 0);
    check("rmid_busy", busy, 0);
    rst = 0;
    step();
    check("rmid_no_rsp", rsp_valid_0, 0);
    req_1 = 1; op_1 = 2'b01; in_1 = 16'h0040; cnt_1 = 4'd2;
    #1 check("rmid_next_gnt1", gnt_1, 1);
    step();
    req_1 = 0;
    check("rmid_next_valid1", rsp_valid_1, 1);
    check("rmid_next_data", rsp_data, 16'h0010);
    rsp_ready_1 = 1;
    step();
    rsp_ready_1 = 0;

    // Rotate (or SLL fallback), then cnt=0 passthrough, then SRA by the maximum count
    req_0 = 1; op_0 = 2'b11; in_0 = 16'h8001; cnt_0 = 4'd1;
    #1 check("rol_gnt0", gnt_0, 1);
    step();
    check("rol_data", rsp_data, ROT_EXP);
    op_0 = 2'b10; in_0 = 16'h1234; cnt_0 = 4'd0; rsp_ready_0 = 1;
    step();
    check("cnt0_data", rsp_data, 16'h1234);
    op_0 = 2'b10; in_0 = 16'h8000; cnt_0 = 4'd15;
    step();
    check("sra15_data", rsp_data, 16'hFFFF);
    req_0 = 0;
    step();
    check("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shift_arb_ctrl.md
Name: shift_arb_ctrl

Overview:
- Arbitrates a single N-bit barrel shifter between two requesters: requester 0 is the execute stage, requester 1 is the address/immediate-generation path.
- Uses round-robin grant with a one-deep result buffer tagged by owner.
- Each response is held until its owner accepts it.
- Sits between the decode/execute control and the shared shift datapath, so one shifter instance serves both paths.

Parameters:
- N, 16, data width of operand and result
- C, 4, shift-count width; count range 0..2^C-1

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_0  input  1  requester 0 has a valid shift request
- op_0  input  2  requester 0 operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL
- in_0  input  N  requester 0 operand
- cnt_0  input  C  requester 0 shift count
- gnt_0  output  1  requester 0 request accepted this cycle
- req_1, op_1, in_1, cnt_1, gnt_1: same as above, for requester 1
- rsp_valid_0  output  1  result buffer holds requester 0's result
- rsp_valid_1  output  1  result buffer holds requester 1's result
- rsp_ready_0  input  1  requester 0 accepts its result
- rsp_ready_1  input  1  requester 1 accepts its result
- rsp_data  output  N  buffered result, shared by both owners
- busy  output  1  result buffer full

Behaviour:
- Reset (async, rst=1):
  - FSM returns to EMPTY.
  - rsp_valid_0 = rsp_valid_1 = 0, rsp_data = 0, busy = 0, gnt_0 = gnt_1 = 0.
  - Round-robin pointer set to favour requester 0.
  - In-flight result discarded; no response is ever issued for it.
- FSM states:
  - EMPTY: buffer free.
  - FULL: buffer holds result and owner tag (tag 0 or 1).
- Slot-free condition, combinational: slot_free = EMPTY, or (FULL and the owner's rsp_ready = 1).
  - In the second case the old result drains and a new one loads in the same cycle (no bubble).
- Grant, combinational, at most one per cycle:
  - Only one requester active and slot_free: grant it.
  - Both active and slot_free: grant the requester not granted most recently (round-robin).
  - Pointer updates only on an actual grant.
  - slot_free = 0: no grant; requesters must hold req and operands stable until granted.
- Issue: on a grant, the selected op/in/cnt drive the shifter; the result is registered into rsp_data on the same clock edge.
  - FSM -> FULL, tag = granted index.
  - Latency: grant cycle N, rsp_valid_<tag> = 1 in cycle N+1.
- Drain:
  - FULL, owner's rsp_ready = 1, no new grant: FSM -> EMPTY, rsp_valid clears next cycle.
  - rsp_ready from the non-owner is ignored.
- Invariants:
  - rsp_valid_0 and rsp_valid_1 are never both 1.
  - busy = FULL.
- Arithmetic (all ops fill in count order; cnt = 0 passes operand unchanged):
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with operand MSB.
  - ROL: bits shifted out of the MSB re-enter at the LSB.
  - cnt = 2^C-1 (15): SLL of 0xFFFF -> 0x8000.
- Simultaneous events: drain of owner 1 plus a new grant to requester 0 in the same cycle -> FULL with tag 0; rsp_valid_1 falls and rsp_valid_0 rises on the same edge.
- Reset asserted mid-transaction: buffer cleared immediately; a requester still holding req after reset is re-arbitrated normally.

Optional Feature:
- Macro: SHIFT_ARB_CTRL_ROTATE_EN
- Defined: op 11 performs ROL as above.
- Not defined:
  - op 11 executes as SLL.
  - No rotate logic is synthesized.
  - All other behaviour is identical.

Test Plan:
- Single SLL: req_0, op=00, in=0x0001, cnt=4 -> gnt_0 in cycle 0; rsp_valid_0 = 1 and rsp_data = 0x0010 in cycle 1; rsp_ready_0 = 1 -> busy = 0 next cycle.
- Arithmetic right shift: req_1, op=10, in=0x8000, cnt=3 -> rsp_data = 0xF000. Then op=01 with the same operands -> 0x1000.
- Contention: req_0 and req_1 held every cycle, rsp_ready both tied 1 -> grants alternate 0,1,0,1 starting with 0 after reset; one result per cycle, no bubble.
- Backpressure: result for requester 0 held with rsp_ready_0 = 0 for 5 cycles while req_1 = 1 -> gnt_1 = 0 and rsp_data stable throughout. rsp_ready_0 = 1 -> gnt_1 in the same cycle, rsp_valid_1 next cycle.
- Reset mid-op: grant in cycle 0, rst pulsed in cycle 1 -> rsp_valid_0 = 0 and rsp_data = 0 asynchronously; no response appears; the next request is served normally.
- Rotate: op=11, in=0x8001, cnt=1 -> 0x0003 with SHIFT_ARB_CTRL_ROTATE_EN defined, 0x0002 without.
